countdown_timer: RTL and testbench

//   mm:ss BCD countdown timer; sits directly downstream of the heartbeat stage and consumes its
//   one-cycle beat (1 Hz at default COUNTS) as the tick input. Loads a preset, counts down
//   on run, raises an alarm at 00:00. Outputs feed the 7-segment display and LED stages.

---
 rtl/countdown_timer_if.sv | 38 +++
 rtl/countdown_timer.sv | 177 +++++++++++++++++
 tb/tb_countdown_timer.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/countdown_timer_if.sv
// countdown_timer_if
//   Groups the control inputs and display/status outputs of countdown_timer.
//   master : drives tick/load/preset/start/stop, observes count and status
//   slave  : the timer itself
//   tick        1  one-cycle count-enable pulse
//   load        1  load preset_min/preset_sec
//   preset_min  8  BCD minutes {tens,units}
//   preset_sec  8  BCD seconds {tens,units}
//   start       1  begin/resume counting
//   stop        1  pause / cancel alarm
//   min_bcd     8  current minutes, BCD
//   sec_bcd     8  current seconds, BCD
//   running     1  counting
//   alarm       1  alarm active
//   done        1  one-cycle expiry pulse
interface countdown_timer_if;
    logic       tick;
    logic       load;
    logic [7:0] preset_min;
    logic [7:0] preset_sec;
    logic       start;
    logic       stop;
    logic [7:0] min_bcd;
    logic [7:0] sec_bcd;
    logic       running;
    logic       alarm;
    logic       done;

    modport master (
        output tick, load, preset_min, preset_sec, start, stop,
        input  min_bcd, sec_bcd, running, alarm, done
    );

    modport slave (
        input  tick, load, preset_min, preset_sec, start, stop,
        output min_bcd, sec_bcd, running, alarm, done
    );
endinterface

// File: rtl/countdown_timer.sv
// countdown_timer
//   mm:ss BCD countdown timer. Loads a BCD preset, counts down one second per
//   tick while running, and raises an alarm on reaching 00:00. The alarm drops
//   after ALARM_TICKS further ticks, on stop, or on a valid load.
//   Optional feature macro: COUNTDOWN_AUTO_RELOAD_EN -- on expiry the count is
//   reloaded from the last accepted preset and counting continues; alarm and
//   done pulse together for one cycle and the ALARM state is never entered.
// Ports
//   clk    in  system clock
//   reset  in  asynchronous, active-high reset
//   bus    slave modport of countdown_timer_if (controls in, count/status out)
// Parameters
//   MAX_MIN      largest accepted minutes preset (decimal 0..99)
//   ALARM_TICKS  ticks the alarm is held after expiry (>=1)
module countdown_timer #(
    parameter int MAX_MIN     = 59,
    parameter int ALARM_TICKS = 5
) (
    input  logic               clk,
    input  logic               reset,
    countdown_timer_if.slave   bus
);

    localparam int AW = (ALARM_TICKS < 2) ? 1 : $clog2(ALARM_TICKS + 1);
    localparam logic [AW-1:0] ALARM_LAST = AW'(ALARM_TICKS - 1);

    typedef enum logic [1:0] {IDLE, RUN, PAUSE, ALARM} state_t;

    typedef struct packed {
        logic [3:0] mt;   // minutes tens
        logic [3:0] mu;   // minutes units
        logic [3:0] st;   // seconds tens
        logic [3:0] su;   // seconds units
    } cnt_t;

    state_t        state, state_n;
    cnt_t          cnt, cnt_n;
    logic [AW-1:0] acnt, acnt_n;
    logic          alarm_q, alarm_n;
    logic          done_q, done_n;
    logic          run_q;

    cnt_t          preset;
    logic          preset_ok;
    logic          cnt_zero;
    logic          cnt_one;
    logic          load_take, stop_take, start_take;

`ifdef COUNTDOWN_AUTO_RELOAD_EN
    cnt_t          rld, rld_n;
`endif

    // One-second BCD decrement with borrow through all four digits.
    // Never called on 00:00 (RUN always holds a nonzero count).
    function automatic cnt_t bcd_dec(input cnt_t c);
        cnt_t r;
        r = c;
        if (c.su != 4'd0) begin
            r.su = c.su - 4'd1;
        end else begin
            r.su = 4'd9;
            if (c.st != 4'd0) begin
                r.st = c.st - 4'd1;
            end else begin
                r.st = 4'd5;
                if (c.mu != 4'd0) begin
                    r.mu = c.mu - 4'd1;
                end else begin
                    r.mu = 4'd9;
                    r.mt = c.mt - 4'd1;
                end
            end
        end
        return r;
    endfunction

    assign preset = {bus.preset_min, bus.preset_sec};

    always_comb begin
        preset_ok = (preset.mt <= 4'd9) && (preset.mu <= 4'd9) &&
                    (preset.st <= 4'd5) && (preset.su <= 4'd9) &&
                    ((int'(preset.mt) * 10 + int'(preset.mu)) <= MAX_MIN);
    end

    assign cnt_zero = (cnt == 16'h0000);
    assign cnt_one  = (cnt == 16'h0001);

    // A command that is refused in the current state is treated as absent,
    // so it does not mask a lower-priority command in the same cycle.
    assign load_take  = bus.load && (state != RUN) && preset_ok;
    assign stop_take  = bus.stop && ((state == RUN) || (state == ALARM));
    assign start_take = bus.start && ((state == IDLE) || (state == PAUSE)) && !cnt_zero;

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        acnt_n  = acnt;
        done_n  = 1'b0;
        alarm_n = 1'b0;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
        rld_n   = rld;
`endif
        if (load_take) begin
            cnt_n   = preset;
            state_n = IDLE;
            acnt_n  = '0;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
            rld_n   = preset;
`endif
        end else if (stop_take) begin
            state_n = (state == RUN) ? PAUSE : IDLE;
            acnt_n  = '0;
        end else if (start_take) begin
            state_n = RUN;
        end else if (bus.tick) begin
            case (state)
                RUN: begin
                    if (cnt_one) begin
                        done_n = 1'b1;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
                        cnt_n   = rld;
                        alarm_n = 1'b1;
`else
                        cnt_n   = '0;
                        state_n = ALARM;
`endif
                    end else begin
                        cnt_n = bcd_dec(cnt);
                    end
                end
                ALARM: begin
                    if (acnt == ALARM_LAST) begin
                        state_n = IDLE;
                        acnt_n  = '0;
                    end else begin
                        acnt_n = acnt + AW'(1);
                    end
                end
                default: ;
            endcase
        end
        if (state_n == ALARM)
            alarm_n = 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            cnt     <= '0;
            acnt    <= '0;
            alarm_q <= 1'b0;
            done_q  <= 1'b0;
            run_q   <= 1'b0;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            acnt    <= acnt_n;
            alarm_q <= alarm_n;
            done_q  <= done_n;
            run_q   <= (state_n == RUN);
        end
    end

`ifdef COUNTDOWN_AUTO_RELOAD_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) rld <= '0;
        else       rld <= rld_n;
    end
`endif

    assign bus.min_bcd = {cnt.mt, cnt.mu};
    assign bus.sec_bcd = {cnt.st, cnt.su};
    assign bus.running = run_q;
    assign bus.alarm   = alarm_q;
    assign bus.done    = done_q;

endmodule

// File: tb/tb_countdown_timer.sv
module tb_countdown_timer;

    logic clk;
    logic reset;
    countdown_timer_if bus ();

    countdown_timer #(.MAX_MIN(59), .ALARM_TICKS(5)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;
    logic [18:0] exp_q[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [18:0] ex(input logic [7:0] m, input logic [7:0] s,
                                       input logic r, input logic a, input logic d);
        return {m, s, r, a, d};
    endfunction

    function automatic logic [18:0] obs();
        return {bus.min_bcd, bus.sec_bcd, bus.running, bus.alarm, bus.done};
    endfunction

    // Drive one cycle of inputs, push the expected post-edge outputs, then
    // pop and compare just after the edge.
    task automatic cyc(input string tag, input logic tk, input logic ld, input logic st,
                       input logic sp, input logic [7:0] pm, input logic [7:0] ps,
                       input logic [18:0] e);
        logic [18:0] want;
        @(negedge clk);
        bus.tick = tk; bus.load = ld; bus.start = st; bus.stop = sp;
        bus.preset_min = pm; bus.preset_sec = ps;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        want = exp_q.pop_front();
        chk(tag, 32'(obs()), 32'(want));
    endtask

    // Shorthands: tick only, idle, load, start, stop
    task automatic tk(input string tag, input logic [18:0] e);
        cyc(tag, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, e);
    endtask
    task automatic ld(input string tag, input logic [7:0] m, input logic [7:0] s, input logic [18:0] e);
        cyc(tag, 1'b0, 1'b1, 1'b0, 1'b0, m, s, e);
    endtask
    task automatic go(input string tag, input logic [18:0] e);
        cyc(tag, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 8'h00, e);
    endtask

    initial begin
        reset = 1'b1;
        bus.tick = 0; bus.load = 0; bus.start = 0; bus.stop = 0;
        bus.preset_min = 0; bus.preset_sec = 0;
        #12;
        chk("reset_state", 32'(obs()), 32'(ex(8'h00, 8'h00, 0, 0, 0)));
        @(negedge clk);
        reset = 1'b0;

        // reset mid-RUN at 01:30
        ld("t1_load", 8'h01, 8'h30, ex(8'h01, 8'h30, 0, 0, 0));
        go("t1_start", ex(8'h01, 8'h30, 1, 0, 0));
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("t1_async_rst", 32'(obs()), 32'(ex(8'h00, 8'h00, 0, 0, 0)));
        @(posedge clk);
        #1;
        chk("t1_rst_held", 32'(obs()), 32'(ex(8'h00, 8'h00, 0, 0, 0)));
        @(negedge clk);
        reset = 1'b0;
        go("t1_start_zero", ex(8'h00, 8'h00, 0, 0, 0));

`ifndef COUNTDOWN_AUTO_RELOAD_EN
        // expiry and alarm timeout
        ld("t2_load", 8'h00, 8'h03, ex(8'h00, 8'h03, 0, 0, 0));
        go("t2_start", ex(8'h00, 8'h03, 1, 0, 0));
        tk("t2_tick1", ex(8'h00, 8'h02, 1, 0, 0));
        tk("t2_tick2", ex(8'h00, 8'h01, 1, 0, 0));
        tk("t2_expire", ex(8'h00, 8'h00, 0, 1, 1));
        cyc("t2_hold", 0, 0, 0, 0, 8'h00, 8'h00, ex(8'h00, 8'h00, 0, 1, 0));
        for (int i = 1; i <= 4; i++)
            tk($sformatf("t2_alarm_tick%0d", i), ex(8'h00, 8'h00, 0, 1, 0));
        tk("t2_alarm_end", ex(8'h00, 8'h00, 0, 0, 0));
        go("t2_idle_start0", ex(8'h00, 8'h00, 0, 0, 0));
`endif

        // minute borrow, invalid presets, load ignored in RUN
        ld("t3_load", 8'h10, 8'h00, ex(8'h10, 8'h00, 0, 0, 0));
        go("t3_start", ex(8'h10, 8'h00, 1, 0, 0));
        tk("t3_borrow", ex(8'h09, 8'h59, 1, 0, 0));
        ld("t3_load_in_run", 8'h00, 8'h05, ex(8'h09, 8'h59, 1, 0, 0));
        cyc("t3_stop", 0, 0, 0, 1, 8'h00, 8'h00, ex(8'h09, 8'h59, 0, 0, 0));
        ld("t3_bad_sec60", 8'h01, 8'h60, ex(8'h09, 8'h59, 0, 0, 0));
        ld("t3_bad_min60", 8'h60, 8'h00, ex(8'h09, 8'h59, 0, 0, 0));
        ld("t3_bad_nibble", 8'h0A, 8'h00, ex(8'h09, 8'h59, 0, 0, 0));
        go("t3_resume", ex(8'h09, 8'h59, 1, 0, 0));
        tk("t3_tick", ex(8'h09, 8'h58, 1, 0, 0));
        cyc("t3_stop2", 0, 0, 0, 1, 8'h00, 8'h00, ex(8'h09, 8'h58, 0, 0, 0));
        ld("t3_max_min", 8'h59, 8'h59, ex(8'h59, 8'h59, 0, 0, 0));

        // simultaneous events
        ld("t4_load", 8'h00, 8'h10, ex(8'h00, 8'h10, 0, 0, 0));
        cyc("t4_start_tick", 1, 0, 1, 0, 8'h00, 8'h00, ex(8'h00, 8'h10, 1, 0, 0));
        cyc("t4_stop_tick", 1, 0, 0, 1, 8'h00, 8'h00, ex(8'h00, 8'h10, 0, 0, 0));
        tk("t4_tick_pause", ex(8'h00, 8'h10, 0, 0, 0));
        cyc("t4_start_tick2", 1, 0, 1, 0, 8'h00, 8'h00, ex(8'h00, 8'h10, 1, 0, 0));
        tk("t4_tick", ex(8'h00, 8'h09, 1, 0, 0));
        cyc("t4_stop", 0, 0, 0, 1, 8'h00, 8'h00, ex(8'h00, 8'h09, 0, 0, 0));
        cyc("t4_load_start", 0, 1, 1, 0, 8'h00, 8'h05, ex(8'h00, 8'h05, 0, 0, 0));
        tk("t4_tick_idle", ex(8'h00, 8'h05, 0, 0, 0));

`ifndef COUNTDOWN_AUTO_RELOAD_EN
        // stop cancels alarm
        ld("t5_load", 8'h00, 8'h01, ex(8'h00, 8'h01, 0, 0, 0));
        go("t5_start", ex(8'h00, 8'h01, 1, 0, 0));
        tk("t5_expire", ex(8'h00, 8'h00, 0, 1, 1));
        go("t5_start_alarm", ex(8'h00, 8'h00, 0, 1, 0));
        cyc("t5_stop", 0, 0, 0, 1, 8'h00, 8'h00, ex(8'h00, 8'h00, 0, 0, 0));
        go("t5_start_zero", ex(8'h00, 8'h00, 0, 0, 0));
        tk("t5_tick_idle", ex(8'h00, 8'h00, 0, 0, 0));
`else
        // auto reload
        ld("t6_load", 8'h00, 8'h02, ex(8'h00, 8'h02, 0, 0, 0));
        go("t6_start", ex(8'h00, 8'h02, 1, 0, 0));
        tk("t6_tick1", ex(8'h00, 8'h01, 1, 0, 0));
        tk("t6_reload1", ex(8'h00, 8'h02, 1, 1, 1));
        tk("t6_tick3", ex(8'h00, 8'h01, 1, 0, 0));
        tk("t6_reload2", ex(8'h00, 8'h02, 1, 1, 1));
        cyc("t6_idle", 0, 0, 0, 0, 8'h00, 8'h00, ex(8'h00, 8'h02, 1, 0, 0));
        cyc("t6_stop", 0, 0, 0, 1, 8'h00, 8'h00, ex(8'h00, 8'h02, 0, 0, 0));
        ld("t6_load0", 8'h00, 8'h00, ex(8'h00, 8'h00, 0, 0, 0));
        go("t6_start0", ex(8'h00, 8'h00, 0, 0, 0));
`endif

        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
